// File: rtl/seq_div_4b_if.sv
// Handshake and data bundle for seq_div_4b: start/N/D in, busy/done/Q/R/err out.
interface seq_div_4b_if #(
    parameter int unsigned W = 4
);
    logic           start;
    logic [2*W-1:0] N;
    logic [W-1:0]   D;
    logic           busy;
    logic           done;
    logic [W-1:0]   Q;
    logic [W-1:0]   R;
    logic           err;

    modport master (
        output start, N, D,
        input  busy, done, Q, R, err
    );

    modport slave (
        input  start, N, D,
        output busy, done, Q, R, err
    );
endinterface

// File: rtl/seq_div_4b.sv
// Sequential restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Define DIV_ERR_CHECK_EN to compile in divide-by-zero / quotient-overflow detection.
module seq_div_4b #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_div_4b_if.slave  bus
);
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  qs_q, qs_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  res_q, res_d;
`ifdef DIV_ERR_CHECK_EN
    logic          err_q, err_d;
    logic          err_pend_q, err_pend_d;
`endif

    logic [W:0]    step_t;
    logic          step_ge;
    logic [W-1:0]  step_rem;
    logic [W-1:0]  step_qs;

    always_comb begin
        step_t   = {rem_q, qs_q[W-1]};
        step_ge  = (step_t >= {1'b0, div_q});
        // Low W bits of t - D equal t[W-1:0] - D modulo 2^W.
        step_rem = step_ge ? (step_t[W-1:0] - div_q) : step_t[W-1:0];
        step_qs  = {qs_q[W-2:0], step_ge};

        state_d = state_q;
        rem_d   = rem_q;
        qs_d    = qs_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        res_d   = res_q;
`ifdef DIV_ERR_CHECK_EN
        err_d      = err_q;
        err_pend_d = err_pend_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = BUSY;
                    busy_d  = 1'b1;
                    rem_d   = bus.N[2*W-1:W];
                    qs_d    = bus.N[W-1:0];
                    div_d   = bus.D;
                    cnt_d   = '0;
`ifdef DIV_ERR_CHECK_EN
                    err_pend_d = (bus.D == '0) || (bus.N[2*W-1:W] >= bus.D);
`endif
                end
            end
            BUSY: begin
`ifdef DIV_ERR_CHECK_EN
                if (err_pend_q) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    quo_d      = '1;
                    res_d      = '0;
                    err_d      = 1'b1;
                    err_pend_d = 1'b0;
                end else
`endif
                begin
                    rem_d = step_rem;
                    qs_d  = step_qs;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        quo_d   = step_qs;
                        res_d   = step_rem;
`ifdef DIV_ERR_CHECK_EN
                        err_d   = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            qs_q    <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            res_q   <= '0;
`ifdef DIV_ERR_CHECK_EN
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            qs_q    <= qs_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
`ifdef DIV_ERR_CHECK_EN
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Q    = quo_q;
    assign bus.R    = res_q;
`ifdef DIV_ERR_CHECK_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif
endmodule

// File: tb/tb_seq_div_4b.sv
// Directed bench for seq_div_4b (W=4): reset, exact/remainder division, back-to-back, errors, abort, loopback.
module tb_seq_div_4b;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_div_4b_if #(.W(4)) bus ();

    seq_div_4b #(.W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: start at edge 0, optionally poke start while busy, inputs scrambled after capture.
    task automatic do_op(input logic [7:0] n, input logic [3:0] d, input logic [3:0] eq,
                         input logic [3:0] er, input logic e_err, input int lat, input bit poke);
        int got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.N     = n;
        bus.D     = d;
        @(posedge clk);
        #1;
        check_eq("busy_at_start", bus.busy, 1'b1);
        check_eq("done_low_at_start", bus.done, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.N     = ~n;
        bus.D     = ~d;
        got = 0;
        for (int k = 1; k <= lat + 4; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                got = k;
                break;
            end
            if (poke && k < lat - 1) begin
                @(negedge clk);
                bus.start = (k == 1);
            end
        end
        check_eq("latency", got, lat);
        check_eq("busy_at_done", bus.busy, 1'b0);
        check_eq("Q", bus.Q, eq);
        check_eq("R", bus.R, er);
        check_eq("err", bus.err, e_err);
    endtask

    initial begin
        int dones;

        // Reset
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.N     = '0;
        bus.D     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_Q", bus.Q, 4'd0);
        check_eq("rst_R", bus.R, 4'd0);
        check_eq("rst_err", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check_eq("idle_no_done", dones, 0);

        // Exact division
        do_op(8'd90,  4'd6,  4'd15, 4'd0, 1'b0, 4, 1'b0);
        do_op(8'd195, 4'd15, 4'd13, 4'd0, 1'b0, 4, 1'b0);

        // Remainder, then back-to-back start at edge W+1
        do_op(8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 4, 1'b0);
        do_op(8'd91,  4'd7, 4'd13, 4'd0, 1'b0, 4, 1'b0);

`ifdef DIV_ERR_CHECK_EN
        do_op(8'd50,  4'd0, 4'hF, 4'd0, 1'b1, 1, 1'b0);
        do_op(8'h5A,  4'd5, 4'hF, 4'd0, 1'b1, 1, 1'b0);
        do_op(8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 4, 1'b0);
`else
        // Raw loop results: 0x33/0 -> Q=F R=3; 0x5A/5 -> Q=F R=F
        do_op(8'h33,  4'd0, 4'hF, 4'h3, 1'b0, 4, 1'b0);
        do_op(8'h5A,  4'd5, 4'hF, 4'hF, 1'b0, 4, 1'b0);
`endif

        // start pulses while busy are ignored
        do_op(8'd77, 4'd9, 4'd8, 4'd5, 1'b0, 4, 1'b1);
        do_op(8'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, 1'b1);

        // Reset at edge 2 aborts the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.N     = 8'd100;
        bus.D     = 4'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", bus.busy, 1'b0);
        check_eq("abort_done", bus.done, 1'b0);
        check_eq("abort_Q", bus.Q, 4'd0);
        check_eq("abort_R", bus.R, 4'd0);
        check_eq("abort_err", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        check_eq("abort_no_done", dones, 0);

        // Multiply-then-divide loopback
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                logic [7:0] prod;
                prod = 8'(a * b);
                do_op(prod, 4'(b), 4'(a), 4'd0, 1'b0, 4, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
